// File: rtl/spi_sclk_edge_gen.sv
// SPI serial-clock divider, toggle counter and transfer FSM with edge strobes for the shift register.
// Define SPI_CS_HOLD_EN to add a HOLD state that stretches busy by divider+1 cycles after the last edge.
module spi_sclk_edge_gen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             start,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] divider,
    input  logic [CNT_W-1:0] char_len,
    output logic             sclk,
    output logic             busy,
    output logic             done,
    output logic             first_edge,
    output logic             leading_edge,
    output logic             trailing_edge,
    output logic             sample_edge,
    output logic             shift_edge
);

`ifdef SPI_CS_HOLD_EN
    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [CNT_W:0]   TglOne = (CNT_W+1)'(1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W:0]     tgl_cnt_q, tgl_cnt_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cpol_q, cpha_q;
    logic [DIV_W-1:0]   divider_q;
    logic [CNT_W-1:0]   char_len_q;

    logic               accept;
    logic               en_tgl;
    logic               last_tgl;
    logic [CNT_W:0]     last_cnt;

    // 2*len-1; char_len of 0 wraps to the all-ones count, i.e. 2^(CNT_W+1)-1
    assign last_cnt = {char_len_q, 1'b0} - TglOne;

    assign accept   = start & ~busy_q & ~abort;
    assign en_tgl   = (state_q == StRun) && (div_cnt_q == divider_q);
    assign last_tgl = en_tgl && (tgl_cnt_q == last_cnt);

    assign first_edge    = accept;
    assign leading_edge  = en_tgl & ~tgl_cnt_q[0] & ~abort;
    assign trailing_edge = en_tgl &  tgl_cnt_q[0] & ~abort;
    assign sample_edge   = cpha_q ? trailing_edge : leading_edge;
    assign shift_edge    = cpha_q ? leading_edge  : trailing_edge;

    assign sclk = sclk_q;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        tgl_cnt_d = tgl_cnt_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                sclk_d    = cpol;
                div_cnt_d = '0;
                tgl_cnt_d = '0;
                if (accept) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d   = StIdle;
                    sclk_d    = cpol_q;
                    div_cnt_d = '0;
                    tgl_cnt_d = '0;
                end else if (en_tgl) begin
                    div_cnt_d = '0;
                    tgl_cnt_d = tgl_cnt_q + TglOne;
                    sclk_d    = ~sclk_q;
                    if (last_tgl) begin
                        tgl_cnt_d = '0;
`ifdef SPI_CS_HOLD_EN
                        state_d = StHold;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivOne;
                end
            end
`ifdef SPI_CS_HOLD_EN
            StHold: begin
                if (abort) begin
                    state_d   = StIdle;
                    div_cnt_d = '0;
                end else if (div_cnt_q == divider_q) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DivOne;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            tgl_cnt_q <= '0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tgl_cnt_q <= tgl_cnt_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Transfer configuration is frozen at start so mid-transfer input changes are ignored
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            divider_q  <= '0;
            char_len_q <= '0;
        end else if (accept) begin
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            divider_q  <= divider;
            char_len_q <= char_len;
        end
    end

endmodule

// File: tb/tb_spi_sclk_edge_gen.sv
// Bench for spi_sclk_edge_gen: per-cycle comparison against an arithmetic transfer-timeline model,
// directed literal checks for the documented scenarios, then randomized traffic.
module tb_spi_sclk_edge_gen;

`ifdef SPI_CS_HOLD_EN
    localparam bit Hold = 1'b1;
`else
    localparam bit Hold = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] divider = '0;
    logic [4:0] char_len = '0;
    logic       sclk, busy, done, first_edge;
    logic       leading_edge, trailing_edge, sample_edge, shift_edge;

    int checks = 0;
    int errors = 0;

    spi_sclk_edge_gen dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .start         (start),
        .abort         (abort),
        .cpol          (cpol),
        .cpha          (cpha),
        .divider       (divider),
        .char_len      (char_len),
        .sclk          (sclk),
        .busy          (busy),
        .done          (done),
        .first_edge    (first_edge),
        .leading_edge  (leading_edge),
        .trailing_edge (trailing_edge),
        .sample_edge   (sample_edge),
        .shift_edge    (shift_edge)
    );

    always #5 pclk = ~pclk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Model: a transfer accepted at cycle s with half-period P and len bits toggles at
    // s+P, s+2P, ..., s+2*len*P; busy covers s+1..end, done lands on end+1.
    bit m_active = 1'b0;
    int m_s = 0;
    int m_P = 1;
    int m_len = 1;
    bit m_p = 1'b0;
    bit m_h = 1'b0;
    bit m_idle_sclk = 1'b0;
    int cyc = 0;

    initial begin : compare
        int t, run_end, end_t;
        bit in_run, is_done, tog, lead, trail, e_sclk, e_fe;
        logic [7:0] exp_v, act_v;
        forever begin
            @(negedge pclk);
            cyc++;
            act_v = {sclk, busy, done, first_edge, leading_edge, trailing_edge,
                     sample_edge, shift_edge};
            if (!presetn) begin
                m_active    = 1'b0;
                m_idle_sclk = 1'b0;
                exp_v       = '0;
            end else begin
                t       = cyc - m_s;
                run_end = 2 * m_len * m_P;
                end_t   = run_end + (Hold ? m_P : 0);
                in_run  = m_active && (t >= 1) && (t <= end_t);
                is_done = m_active && (t == end_t + 1);
                tog     = in_run && (t <= run_end) && (t % m_P == 0) && !abort;
                lead    = tog && ((((t / m_P) - 1) % 2) == 0);
                trail   = tog && ((((t / m_P) - 1) % 2) == 1);
                if (in_run && t <= run_end) e_sclk = m_p ^ ((((t - 1) / m_P) % 2) != 0);
                else if (in_run)            e_sclk = m_p;
                else                        e_sclk = m_idle_sclk;
                e_fe  = !in_run && start && !abort;
                exp_v = {e_sclk, in_run, is_done, e_fe, lead, trail,
                         m_h ? trail : lead, m_h ? lead : trail};
                if (in_run) begin
                    if (abort) begin
                        m_active    = 1'b0;
                        m_idle_sclk = m_p;
                    end else if (t == end_t) begin
                        m_idle_sclk = m_p;
                    end
                end else begin
                    if (is_done) m_active = 1'b0;
                    m_idle_sclk = cpol;
                    if (start && !abort) begin
                        m_active = 1'b1;
                        m_s      = cyc;
                        m_P      = int'(divider) + 1;
                        m_len    = (char_len == 0) ? 32 : int'(char_len);
                        m_p      = cpol;
                        m_h      = cpha;
                    end
                end
            end
            chk($sformatf("outputs cyc %0d {sclk,busy,done,fe,lead,trail,samp,shift}", cyc),
                int'(act_v), int'(exp_v));
        end
    end

    // Called just after a rising edge; that cycle is offset 0 (start presented).
    task automatic run_xfer(input bit p, input bit h, input int dv, input int cl,
                            input bit hold_start,
                            output int lead_n, output int trail_n, output int first_lead,
                            output int done_off, output int busy_n, output int fe_n,
                            output int samp_n, output int shft_n, output int sclk_done);
        int len, end_t;
        len = (cl == 0) ? 32 : cl;
        end_t = 2 * len * (dv + 1) + (Hold ? dv + 1 : 0);
        lead_n = 0; trail_n = 0; first_lead = -1; done_off = -1;
        busy_n = 0; fe_n = 0; samp_n = 0; shft_n = 0; sclk_done = -1;
        cpol = p; cpha = h; divider = 8'(dv); char_len = 5'(cl); abort = 1'b0; start = 1'b1;
        for (int off = 0; off < 4000; off++) begin
            @(negedge pclk);
            if (leading_edge) begin
                lead_n++;
                if (first_lead < 0) first_lead = off;
            end
            if (trailing_edge) trail_n++;
            busy_n += int'(busy);
            fe_n += int'(first_edge);
            samp_n += int'(sample_edge & (h ? trailing_edge : leading_edge));
            shft_n += int'(shift_edge & (h ? leading_edge : trailing_edge));
            if (done) begin
                done_off = off;
                sclk_done = int'(sclk);
                break;
            end
            @(posedge pclk);
            #1;
            start = hold_start && (off + 1 <= end_t);
        end
        @(posedge pclk);
        #1;
        start = 1'b0;
    endtask

    initial begin : stim
        int ln, tn, fl, dn, bn, fn, sn, hn, sd;
        repeat (2) @(posedge pclk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset sclk", int'(sclk), 0);
        chk("reset done", int'(done), 0);
        presetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1;

        // Mode 0, divider 1, 8 bits
        run_xfer(1'b0, 1'b0, 1, 8, 1'b0, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("m0 first leading offset", fl, 2);
        chk("m0 leading count", ln, 8);
        chk("m0 trailing count", tn, 8);
        chk("m0 sample on leading", sn, 8);
        chk("m0 shift on trailing", hn, 8);
        chk("m0 busy cycles", bn, Hold ? 34 : 32);
        chk("m0 done offset", dn, Hold ? 35 : 33);
        chk("m0 sclk at done", sd, 0);
        chk("m0 first_edge count", fn, 1);

        // Mode 3, divider 0, 4 bits: let sclk settle high first
        cpol = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk("m3 idle sclk", int'(sclk), 1);
        run_xfer(1'b1, 1'b1, 0, 4, 1'b0, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("m3 first leading offset", fl, 1);
        chk("m3 leading count", ln, 4);
        chk("m3 trailing count", tn, 4);
        chk("m3 sample on trailing", sn, 4);
        chk("m3 shift on leading", hn, 4);
        chk("m3 done offset", dn, Hold ? 10 : 9);
        chk("m3 sclk at done", sd, 1);

        // char_len 0 encodes 32 bits
        run_xfer(1'b0, 1'b0, 0, 0, 1'b0, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("len0 leading count", ln, 32);
        chk("len0 trailing count", tn, 32);
        chk("len0 done offset", dn, Hold ? 66 : 65);

        // Abort on the 3rd leading edge (offset 10), restart two cycles later
        cpol = 1'b0; cpha = 1'b0; divider = 8'd1; char_len = 5'd8; start = 1'b1;
        @(posedge pclk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge pclk);
        #1;
        abort = 1'b1;
        @(negedge pclk);
        chk("abort busy during abort cycle", int'(busy), 1);
        chk("abort leading suppressed", int'(leading_edge), 0);
        @(posedge pclk);
        #1;
        abort = 1'b0;
        @(negedge pclk);
        chk("abort busy after", int'(busy), 0);
        chk("abort sclk after", int'(sclk), 0);
        chk("abort no done", int'(done), 0);
        @(posedge pclk);
        #1;
        run_xfer(1'b0, 1'b0, 1, 8, 1'b0, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("post-abort done offset", dn, Hold ? 35 : 33);
        chk("post-abort leading count", ln, 8);

        // start held high throughout a transfer
        run_xfer(1'b0, 1'b1, 1, 2, 1'b1, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("held start first_edge count", fn, 1);
        chk("held start done offset", dn, Hold ? 11 : 9);

        // start and abort together in idle
        start = 1'b1; abort = 1'b1;
        @(negedge pclk);
        chk("start+abort no first_edge", int'(first_edge), 0);
        @(posedge pclk);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge pclk);
        chk("start+abort no busy", int'(busy), 0);
        @(posedge pclk);
        #1;

        // Chip-select hold scenario: divider 3, 2 bits
        run_xfer(1'b0, 1'b0, 3, 2, 1'b0, ln, tn, fl, dn, bn, fn, sn, hn, sd);
        chk("cshold busy cycles", bn, Hold ? 20 : 16);
        chk("cshold done offset", dn, Hold ? 21 : 17);

        // Asynchronous reset mid-transfer
        cpol = 1'b1; cpha = 1'b0; divider = 8'd2; char_len = 5'd8; start = 1'b1;
        @(posedge pclk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge pclk);
        #1;
        presetn = 1'b0;
        #1;
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset sclk", int'(sclk), 0);
        @(posedge pclk);
        #1;
        presetn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            @(posedge pclk);
            #1;
            presetn  = ($urandom_range(0, 1999) != 0);
            start    = presetn && ($urandom_range(0, 9) == 0);
            abort    = ($urandom_range(0, 299) == 0);
            cpol     = 1'($urandom);
            cpha     = 1'($urandom);
            divider  = 8'($urandom_range(0, 3));
            char_len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(1, 4));
        end
        @(posedge pclk);
        #1;
        presetn = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sclk_edge_gen.md
Name: spi_sclk_edge_gen

Overview:
Parametrised SPI serial-clock and edge-strobe generator for the SPI master datapath. Accepts a transfer start, divides pclk into SCLK half-periods, and counts the programmed character length. Drives SCLK with the selected CPOL and issues single-cycle leading, trailing, sample, shift and first-edge strobes to the shift register. Replaces the fixed-mode combinational edge decode with a self-contained divider, toggle counter and transfer FSM that supports all four CPOL/CPHA modes.

Parameters:
DIV_W, 8, width of the clock divider value; half-period = divider+1 pclk cycles.
CNT_W, 5, width of char_len; a transfer is 1..2^CNT_W bits.

Ports:
pclk  in  1  system clock
presetn  in  1  asynchronous active-low reset
start  in  1  transfer request pulse; accepted only in IDLE
abort  in  1  synchronous cancel of the current transfer
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
divider  in  DIV_W  half-period minus one
char_len  in  CNT_W  bits per transfer; 0 encodes 2^CNT_W
sclk  out  1  serial clock, registered
busy  out  1  transfer in progress, registered
done  out  1  one-cycle end-of-transfer pulse, registered
first_edge  out  1  one-cycle pulse in the cycle a start is accepted
leading_edge  out  1  strobe in the cycle before SCLK leaves idle level
trailing_edge  out  1  strobe in the cycle before SCLK returns to idle level
sample_edge  out  1  equals leading_edge if cpha=0, else trailing_edge
shift_edge  out  1  equals trailing_edge if cpha=0, else leading_edge

Behaviour:
- Clock pclk; reset presetn is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, sclk=0, div_cnt=0, tgl_cnt=0. The cpol register resets to 0. All strobes are 0.
- cpol, cpha, divider and char_len are captured on start acceptance. Input changes during a transfer have no effect.
- In IDLE, sclk equals the registered cpol. It follows the live cpol input only while IDLE, with one cycle of latency.
- FSM states: IDLE and RUN (plus HOLD when the optional feature is enabled).
- IDLE->RUN when start=1 and abort=0. first_edge = start & ~busy & ~abort, combinational, asserted in that cycle. Next cycle: busy=1, div_cnt=0, tgl_cnt=0.
- RUN: div_cnt increments each cycle. en_tgl = (div_cnt==divider_q). On en_tgl, div_cnt reloads to 0.
  - en_tgl with tgl_cnt even asserts leading_edge. en_tgl with tgl_cnt odd asserts trailing_edge.
  - On each en_tgl, sclk toggles at the end of the cycle and tgl_cnt increments. tgl_cnt is CNT_W+1 bits wide.
- Last toggle is tgl_cnt==2*len-1. After it, RUN->IDLE: busy=0 and done=1 for one cycle, in the cycle following that trailing edge. sclk ends at cpol_q.
- divider=0: toggle every cycle; SCLK = pclk/2.
- start while busy: ignored, no strobe.
- abort in RUN: next cycle IDLE, busy=0, sclk=cpol_q, counters cleared, done=0, strobes suppressed in the abort cycle.
- abort and start together in IDLE: abort wins; no transfer, no first_edge.
- presetn low mid-transfer: immediate return to reset values.
- All strobes are mutually exclusive with done. They are never asserted while busy=0, except first_edge.

Optional Feature:
SPI_CS_HOLD_EN:
- Defined: after the last trailing edge, the FSM enters HOLD for divider_q+1 cycles with busy=1, sclk at idle level and no strobes. It then goes to IDLE, and done pulses in the cycle after HOLD ends. This provides chip-select hold time. abort in HOLD exits immediately without done.
- Undefined: no HOLD state; done timing as in Behaviour.

Test Plan:
- Mode 0, divider=1, char_len=8, start at cycle 0 -> first_edge cycle 0; busy cycles 1..32. Leading_edge at cycles 2,6,...,30 and trailing at 4,8,...,32 (8 each). sample=leading. sclk 0->1 after cycle 2. done cycle 33, sclk=0.
- Mode 3 (cpol=1, cpha=1), divider=0, char_len=4 -> sclk idles 1 and first falls after cycle 1. 8 toggles on consecutive cycles. sample_edge on the 4 trailing strobes, shift_edge on the 4 leading strobes. done 1 cycle after the final toggle, sclk=1.
- char_len=0, CNT_W=5, divider=0 -> exactly 64 toggles (32 leading, 32 trailing), then done.
- abort asserted at the 3rd leading edge -> strobe suppressed, busy=0 next cycle, sclk=cpol, no done. A start 2 cycles later transfers normally.
- start held high through the whole transfer, and start+abort together in IDLE -> only one first_edge, no restart while busy; simultaneous start+abort produces no transfer.
- SPI_CS_HOLD_EN, divider=3, char_len=2 -> after the final trailing edge, busy stays 1 for 4 extra cycles with no strobes; then done. Same stimulus without the macro -> done 4 cycles earlier.
